// File: rtl/out_pack_framer.sv
// -----------------------------------------------------------------------------
// out_pack_framer
//
// Packs a DWIDTH-bit AXI-Stream of beats into 2*DWIDTH-bit words. Each word
// carries its beats' weight_switch sideband. The block closes a frame on input
// tlast, on a weight_switch change, or when a burst reaches MAX_BURST words.
// The master side is fully registered, so no combinational path runs from
// s_axis_* to m_axis_*.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_axis_tdata       input beat (DWIDTH)
//   s_axis_tvalid      input valid
//   s_axis_tready      input ready (combinational, 0 while in reset)
//   s_axis_tlast       input end of packet
//   weight_switch_in   sideband, qualified by s_axis_tvalid
//   m_axis_tdata       packed word, first beat in [DWIDTH-1:0]
//   m_axis_tkeep       byte enables, upper half zero on padded words
//   m_axis_tvalid      output valid
//   m_axis_tready      output ready
//   m_axis_tlast       end of frame
//   weight_switch_out  weight_switch of the word's beats
//   frame_cnt          number of tlast words emitted, wraps modulo 2^CNTW
// -----------------------------------------------------------------------------
module out_pack_framer #(
    parameter int DWIDTH    = 128,
    parameter int MAX_BURST = 16,
    parameter int CNTW      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DWIDTH-1:0]       s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    weight_switch_in,
    output logic [2*DWIDTH-1:0]     m_axis_tdata,
    output logic [2*DWIDTH/8-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    weight_switch_out,
    output logic [CNTW-1:0]         frame_cnt
);

    localparam int KW = 2 * DWIDTH / 8;
    // bcnt never exceeds MAX_BURST-1, so this width is enough.
    localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

    localparam logic [KW-1:0] KEEP_LO  = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};
    localparam logic [KW-1:0] KEEP_ALL = {KW{1'b1}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DWIDTH-1:0]   lo_data;
    logic                lo_ws;
    logic [BW-1:0]       bcnt;

    logic                out_free;
    logic                force_last;
    logic                accept;
    logic                flush;

    logic                emit;
    logic [2*DWIDTH-1:0] emit_data;
    logic [KW-1:0]       emit_keep;
    logic                emit_last;
    logic                emit_ws;
    logic                lo_load;

    assign out_free   = !m_axis_tvalid || m_axis_tready;
    assign force_last = (bcnt == BW'(MAX_BURST - 1));

    // A held half only pairs with a beat of the same weight_switch. A beat
    // with a different weight_switch is refused until the half is flushed.
    assign s_axis_tready = rst_n && out_free &&
                           ((state_q == ST_EMPTY) || (weight_switch_in == lo_ws));

    assign accept = s_axis_tvalid && s_axis_tready;

    // A mismatched beat waiting on a held half pushes the half out padded.
    assign flush  = (state_q == ST_HALF) && s_axis_tvalid && out_free &&
                    (weight_switch_in != lo_ws);

    // State register.
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of the order the always blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: each combinational output gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept && !s_axis_tlast) state_d = ST_HALF;
            ST_HALF:  if (accept || flush)         state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Output decode: what, if anything, loads into the output register.
    always_comb begin
        emit      = 1'b0;
        emit_data = '0;
        emit_keep = '0;
        emit_last = 1'b0;
        emit_ws   = 1'b0;
        lo_load   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        // Lone closing beat goes out padded.
                        emit      = 1'b1;
                        emit_data = {{DWIDTH{1'b0}}, s_axis_tdata};
                        emit_keep = KEEP_LO;
                        emit_last = 1'b1;
                        emit_ws   = weight_switch_in;
                    end else begin
                        lo_load = 1'b1;
                    end
                end
            end
            ST_HALF: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_data = {s_axis_tdata, lo_data};
                    emit_keep = KEEP_ALL;
                    // The input tlast and the burst limit merge into one tlast.
                    emit_last = s_axis_tlast || force_last;
                    emit_ws   = lo_ws;
                end else if (flush) begin
                    emit      = 1'b1;
                    emit_data = {{DWIDTH{1'b0}}, lo_data};
                    emit_keep = KEEP_LO;
                    emit_last = 1'b1;
                    emit_ws   = lo_ws;
                end
            end
            default: ;
        endcase
    end

    // Holding register for the first beat of a pair.
    // NOTE: the data registers are reset along with the control state so
    // that the output word and the held half are deterministic after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_data <= '0;
            lo_ws   <= 1'b0;
        end else if (lo_load) begin
            lo_data <= s_axis_tdata;
            lo_ws   <= weight_switch_in;
        end
    end

    // Output register. emit only fires when out_free, so a held word is
    // never overwritten, and a word consumed on the same edge as a new load
    // keeps tvalid high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid     <= 1'b0;
            m_axis_tdata      <= '0;
            m_axis_tkeep      <= '0;
            m_axis_tlast      <= 1'b0;
            weight_switch_out <= 1'b0;
        end else if (emit) begin
            m_axis_tvalid     <= 1'b1;
            m_axis_tdata      <= emit_data;
            m_axis_tkeep      <= emit_keep;
            m_axis_tlast      <= emit_last;
            weight_switch_out <= emit_ws;
        end else if (m_axis_tready) begin
            m_axis_tvalid     <= 1'b0;
        end
    end

    // Burst length and frame counters advance when a word is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt      <= '0;
            frame_cnt <= '0;
        end else if (emit) begin
            if (emit_last) begin
                bcnt      <= '0;
                frame_cnt <= frame_cnt + CNTW'(1);
            end else begin
                bcnt      <= bcnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_out_pack_framer.sv
// -----------------------------------------------------------------------------
// tb_out_pack_framer
//
// Self-checking bench for out_pack_framer (DWIDTH=16, MAX_BURST=4). A
// sequence-level reference model turns each observed input event into the
// expected output words. A single compare process checks valid, data, keep,
// last, ws, tready, frame_cnt and stall stability on every cycle. Directed
// tests pin the model with hand-computed literal words.
// -----------------------------------------------------------------------------
module tb_out_pack_framer;

    localparam int DW = 16;
    localparam int MB = 4;
    localparam int CW = 16;
    localparam int KW = 2 * DW / 8;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [KW-1:0]   keep;
        logic            last;
        logic            ws;
    } word_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic            weight_switch_in;
    logic [2*DW-1:0] m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            weight_switch_out;
    logic [CW-1:0]   frame_cnt;

    out_pack_framer #(.DWIDTH(DW), .MAX_BURST(MB), .CNTW(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .weight_switch_in  (weight_switch_in),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .weight_switch_out (weight_switch_out),
        .frame_cnt         (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    word_t         exp_q[$];
    word_t         seen[$];
    logic          pend;
    logic [DW-1:0] pend_data;
    logic          pend_ws;
    int            burst;
    int            exp_frames;
    logic          stall_prev;
    word_t         prev_w;
    int            ready_mode;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        pend       = 1'b0;
        pend_data  = '0;
        pend_ws    = 1'b0;
        burst      = 0;
        exp_frames = 0;
        stall_prev = 1'b0;
    endtask

    // Append an expected word; tracks burst length and frame count.
    task automatic push_word(input logic [2*DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic w);
        word_t nw;
        nw.data = d;
        nw.keep = k;
        nw.last = l;
        nw.ws   = w;
        exp_q.push_back(nw);
        if (l) begin
            burst = 0;
            exp_frames++;
        end else begin
            burst++;
        end
    endtask

    // Compare process: runs on the falling edge, between the driving edges.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic  out_free;
                logic  exp_ready;
                word_t got;
                logic [KW-1:0] keep_lo;
                keep_lo = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};

                check("m_valid", m_axis_tvalid, exp_q.size() != 0);
                check("frame_cnt", frame_cnt, CW'(exp_frames));
                if (stall_prev) begin
                    check("stall_valid", m_axis_tvalid, 1'b1);
                    check("stall_data", m_axis_tdata, prev_w.data);
                    check("stall_keep", m_axis_tkeep, prev_w.keep);
                    check("stall_last", m_axis_tlast, prev_w.last);
                    check("stall_ws", weight_switch_out, prev_w.ws);
                end

                out_free  = !m_axis_tvalid || m_axis_tready;
                exp_ready = out_free && (!pend || (weight_switch_in == pend_ws));
                check("s_ready", s_axis_tready, exp_ready);

                // Word handshaken at the coming edge.
                if (m_axis_tvalid && m_axis_tready && exp_q.size() != 0) begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("out_data", m_axis_tdata, e.data);
                    check("out_keep", m_axis_tkeep, e.keep);
                    check("out_last", m_axis_tlast, e.last);
                    check("out_ws", weight_switch_out, e.ws);
                    got.data = m_axis_tdata;
                    got.keep = m_axis_tkeep;
                    got.last = m_axis_tlast;
                    got.ws   = weight_switch_out;
                    seen.push_back(got);
                end

                // Input side at the coming edge.
                if (s_axis_tvalid && pend && (weight_switch_in != pend_ws) && out_free) begin
                    push_word({{DW{1'b0}}, pend_data}, keep_lo, 1'b1, pend_ws);
                    pend = 1'b0;
                end else if (s_axis_tvalid && s_axis_tready) begin
                    if (!pend) begin
                        if (s_axis_tlast) begin
                            push_word({{DW{1'b0}}, s_axis_tdata}, keep_lo, 1'b1, weight_switch_in);
                        end else begin
                            pend      = 1'b1;
                            pend_data = s_axis_tdata;
                            pend_ws   = weight_switch_in;
                        end
                    end else begin
                        push_word({s_axis_tdata, pend_data}, {KW{1'b1}},
                                  s_axis_tlast || (burst == MB - 1), pend_ws);
                        pend = 1'b0;
                    end
                end

                stall_prev  = m_axis_tvalid && !m_axis_tready;
                prev_w.data = m_axis_tdata;
                prev_w.keep = m_axis_tkeep;
                prev_w.last = m_axis_tlast;
                prev_w.ws   = weight_switch_out;
            end
        end
    end

    // Output ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Present a beat and hold it until accepted; waits = cycles refused.
    task automatic send_beat(input logic [DW-1:0] d, input logic w, input logic l,
                             output int waits);
        logic acc;
        s_axis_tdata     = d;
        weight_switch_in = w;
        s_axis_tlast     = l;
        s_axis_tvalid    = 1'b1;
        waits            = 0;
        forever begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 500) begin
                check("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", n < 400, 1'b1);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen.delete();
    endtask

    int   w;
    logic ws_r;
    logic [DW-1:0] d;
    logic l;

    initial begin
        rst_n            = 1'b0;
        s_axis_tdata     = '0;
        s_axis_tvalid    = 1'b0;
        s_axis_tlast     = 1'b0;
        weight_switch_in = 1'b0;
        m_axis_tready    = 1'b0;
        ready_mode       = 0;
        reset_model();

        // Reset state.
        #1;
        check("rst_valid", m_axis_tvalid, 1'b0);
        check("rst_data", m_axis_tdata, '0);
        check("rst_keep", m_axis_tkeep, '0);
        check("rst_last", m_axis_tlast, 1'b0);
        check("rst_ws", weight_switch_out, 1'b0);
        check("rst_frame_cnt", frame_cnt, '0);
        check("rst_s_ready", s_axis_tready, 1'b0);
        do_reset();

        // Packing: four beats, tlast on the fourth.
        send_beat(16'hA0A0, 1'b0, 1'b0, w);
        send_beat(16'hB0B0, 1'b0, 1'b0, w);
        send_beat(16'hC0C0, 1'b0, 1'b0, w);
        send_beat(16'hD0D0, 1'b0, 1'b1, w);
        drain();
        check("pack_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check("pack_w0_data", seen[0].data, 32'hB0B0A0A0);
            check("pack_w0_last", seen[0].last, 1'b0);
            check("pack_w0_keep", seen[0].keep, 4'hF);
            check("pack_w1_data", seen[1].data, 32'hD0D0C0C0);
            check("pack_w1_last", seen[1].last, 1'b1);
            check("pack_w1_keep", seen[1].keep, 4'hF);
        end
        check("pack_frame_cnt", frame_cnt, 1);

        // Lone tlast beat.
        do_reset();
        send_beat(16'h1111, 1'b0, 1'b0, w);
        send_beat(16'h2222, 1'b0, 1'b0, w);
        send_beat(16'h3333, 1'b0, 1'b1, w);
        drain();
        check("lone_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check("lone_w0_data", seen[0].data, 32'h22221111);
            check("lone_w0_last", seen[0].last, 1'b0);
            check("lone_w1_data", seen[1].data, 32'h00003333);
            check("lone_w1_keep", seen[1].keep, 4'h3);
            check("lone_w1_last", seen[1].last, 1'b1);
        end

        // Weight switch flush.
        do_reset();
        send_beat(16'hAAAA, 1'b0, 1'b0, w);
        send_beat(16'hBBBB, 1'b1, 1'b1, w);
        check("flush_refused_cycles", w, 1);
        drain();
        check("flush_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check("flush_w0_data", seen[0].data, 32'h0000AAAA);
            check("flush_w0_keep", seen[0].keep, 4'h3);
            check("flush_w0_last", seen[0].last, 1'b1);
            check("flush_w0_ws", seen[0].ws, 1'b0);
            check("flush_w1_data", seen[1].data, 32'h0000BBBB);
            check("flush_w1_ws", seen[1].ws, 1'b1);
        end
        check("flush_frame_cnt", frame_cnt, 2);

        // Burst limit: 20 beats, only the last carries tlast.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_beat(DW'(16'h1000 + i), 1'b0, i == 19, w);
        end
        drain();
        check("burst_count", seen.size(), 10);
        if (seen.size() == 10) begin
            check("burst_w0_data", seen[0].data, 32'h10011000);
            for (int k = 0; k < 10; k++) begin
                check("burst_last", seen[k].last, (k == 3) || (k == 7) || (k == 9));
            end
        end
        check("burst_frame_cnt", frame_cnt, 3);

        // Reset with a stalled output word and a blocked beat.
        do_reset();
        ready_mode = 2;
        send_beat(16'h5555, 1'b0, 1'b1, w);
        idle(1);
        check("pre_rst_valid", m_axis_tvalid, 1'b1);
        check("pre_rst_frame_cnt", frame_cnt, 1);
        s_axis_tdata  = 16'h6666;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check("mid_rst_valid", m_axis_tvalid, 1'b0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_s_ready", s_axis_tready, 1'b0);
        s_axis_tvalid = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen.delete();

        // Reset while holding a half, then a fresh pair.
        send_beat(16'h7777, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        reset_model();
        #1;
        check("half_rst_s_ready", s_axis_tready, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen.delete();
        send_beat(16'h8888, 1'b1, 1'b0, w);
        send_beat(16'h9999, 1'b1, 1'b1, w);
        drain();
        check("fresh_count", seen.size(), 1);
        if (seen.size() == 1) begin
            check("fresh_data", seen[0].data, 32'h99998888);
            check("fresh_last", seen[0].last, 1'b1);
            check("fresh_ws", seen[0].ws, 1'b1);
        end

        // Random stream with random backpressure.
        do_reset();
        ready_mode = 1;
        ws_r = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            d = DW'($urandom);
            if ($urandom_range(0, 7) == 0) ws_r = ~ws_r;
            l = (i == 999) || ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat(d, ws_r, l, w);
        end
        drain();
        check("rand_pending_half", pend, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
